// File: rtl/alu_pkg.sv
// Shared ALU operation encodings and execution-unit FSM state type.
// The ALU decoder and the execute stage both import these definitions.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_MUL  = 4'b0011;
    localparam logic [3:0] ALU_DIVU = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_XOR  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b1001;
    localparam logic [3:0] ALU_SRL  = 4'b1010;
    localparam logic [3:0] ALU_NOR  = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    // True for legal codes that complete in a single cycle.
    function automatic logic is_single(input logic [3:0] code);
        logic hit;
        hit = 1'b0;
        case (code)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT,
            ALU_NOR, ALU_XOR, ALU_SLL, ALU_SRL: hit = 1'b1;
            default:                            hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// Exposes the next-step values so the owner can capture the final step directly.
module alu_muldiv_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             fin,
    output logic [WIDTH-1:0] lo_next_c,
    output logic [WIDTH-1:0] hi_next_c
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] m;
    logic             div_mode;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   sum_c;
    logic [WIDTH:0]   shifted_c;
    logic [WIDTH:0]   diff_c;

    // One multiply or divide step on the {hi, lo} working pair.
    always_comb begin
        sum_c     = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
        shifted_c = {hi, lo[WIDTH-1]};
        diff_c    = shifted_c - {1'b0, m};
        lo_next_c = lo;
        hi_next_c = hi;
        if (div_mode) begin
            if (!diff_c[WIDTH]) begin
                hi_next_c = diff_c[WIDTH-1:0];
                lo_next_c = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_next_c = shifted_c[WIDTH-1:0];
                lo_next_c = {lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_next_c = sum_c[WIDTH:1];
            lo_next_c = {sum_c[0], lo[WIDTH-1:1]};
        end
    end

    // The step being computed now is the last one.
    assign fin = (count == CW'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi       <= '0;
            lo       <= '0;
            m        <= '0;
            div_mode <= 1'b0;
            count    <= '0;
        end else if (go) begin
            hi       <= '0;
            lo       <= a;
            m        <= b;
            div_mode <= is_div;
            count    <= CW'(WIDTH);
        end else if (count != '0) begin
            hi       <= hi_next_c;
            lo       <= lo_next_c;
            count    <= count - CW'(1);
        end
    end

endmodule

// File: rtl/alu_exec.sv
// Multi-cycle ALU execution unit: single-cycle logic/arith/shift ops plus
// iterative unsigned MUL/DIVU, with a start/busy/done handshake to the controller.
module alu_exec
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alucontrol,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             illegal,
    output logic             busy,
    output logic             done
);

    localparam int unsigned SHW = $clog2(WIDTH);

    state_t           state, state_n;
    logic [WIDTH-1:0] result_n, result_hi_n;
    logic             zero_n, illegal_n, busy_n, done_n;

    logic [WIDTH-1:0] alu_c;
    logic [SHW-1:0]   shamt_c;
    logic             slt_c;
    logic             go_c, is_div_c, fin;
    logic [WIDTH-1:0] iter_lo_c, iter_hi_c;

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk       (clk),
        .reset     (reset),
        .go        (go_c),
        .is_div    (is_div_c),
        .a         (a),
        .b         (b),
        .fin       (fin),
        .lo_next_c (iter_lo_c),
        .hi_next_c (iter_hi_c)
    );

    // Single-cycle datapath; shifts use only the low bits of b.
    always_comb begin
        shamt_c = b[SHW-1:0];
        slt_c   = ($signed(a) < $signed(b));
        alu_c   = '0;
        case (alucontrol)
            ALU_AND: alu_c = a & b;
            ALU_OR:  alu_c = a | b;
            ALU_ADD: alu_c = a + b;
            ALU_SUB: alu_c = a - b;
            ALU_SLT: alu_c = {{(WIDTH-1){1'b0}}, slt_c};
            ALU_NOR: alu_c = ~(a | b);
            ALU_XOR: alu_c = a ^ b;
            ALU_SLL: alu_c = a << shamt_c;
            ALU_SRL: alu_c = a >> shamt_c;
            default: alu_c = '0;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_n     = state;
        result_n    = result;
        result_hi_n = result_hi;
        zero_n      = zero;
        illegal_n   = illegal;
        busy_n      = busy;
        done_n      = 1'b0;
        go_c        = 1'b0;
        is_div_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (alucontrol == ALU_MUL) begin
                        go_c    = 1'b1;
                        busy_n  = 1'b1;
                        state_n = ST_MUL;
                    end else if (alucontrol == ALU_DIVU && b != '0) begin
                        go_c     = 1'b1;
                        is_div_c = 1'b1;
                        busy_n   = 1'b1;
                        state_n  = ST_DIV;
                    end else if (alucontrol == ALU_DIVU) begin
                        // Divide by zero resolves immediately.
                        result_n    = '1;
                        result_hi_n = a;
                        zero_n      = 1'b0;
                        illegal_n   = 1'b0;
                        done_n      = 1'b1;
                    end else if (is_single(alucontrol)) begin
                        result_n    = alu_c;
                        result_hi_n = '0;
                        zero_n      = (alu_c == '0);
                        illegal_n   = 1'b0;
                        done_n      = 1'b1;
                    end else begin
                        result_n    = '0;
                        result_hi_n = '0;
                        zero_n      = 1'b1;
                        illegal_n   = 1'b1;
                        done_n      = 1'b1;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                if (fin) begin
                    result_n    = iter_lo_c;
                    result_hi_n = iter_hi_c;
                    zero_n      = (iter_lo_c == '0);
                    illegal_n   = 1'b0;
                    done_n      = 1'b1;
                    busy_n      = 1'b0;
                    state_n     = ST_IDLE;
                end
            end
            default: begin
                busy_n  = 1'b0;
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            result    <= '0;
            result_hi <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            result    <= result_n;
            result_hi <= result_hi_n;
            zero      <= zero_n;
            illegal   <= illegal_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

endmodule
